store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- FIFO write buffer between the EX/MEM pipeline register and the data memory.
- Accepts lane-aligned store requests (word address, byte enables, data), queues them, and drains one per cycle to the data memory write port when the memory accepts.
- Provides a combinational load-probe port so the MEM stage can merge pending store bytes into load data (store-to-load forwarding).

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request this cycle.
- st_ready  output  1  buffer can accept; equals !full.
- st_addr  input  32  byte address; only [31:2] is stored.
- st_be  input  4  byte enables, lane-aligned (bit i = byte [8i+7:8i]).
- st_data  input  32  lane-aligned write data.
- st_pc  input  32  PC of the store instruction, carried for trace.
- dm_we  output  1  head entry valid for the memory.
- dm_ready  input  1  memory accepts the head this cycle.
- dm_addr  output  32  {head word address, 2'b00}.
- dm_be  output  4  head byte enables.
- dm_wdata  output  32  head data.
- dm_pc  output  32  head PC.
- ld_addr  input  32  load probe byte address.
- ld_hit_be  output  4  lanes supplied by the buffer.
- ld_hit_data  output  32  forwarded bytes; lanes not in ld_hit_be are 0.
- ld_full_hit  output  1  all four lanes covered (ld_hit_be == 4'b1111).
- empty  output  1  count == 0.
- count  output  AW+1  number of occupied entries.

Behaviour:
- State:
  - DEPTH entries of {waddr[29:0], be[3:0], data[31:0], pc[31:0]}.
  - head and tail pointers (AW bits, wrap modulo DEPTH).
  - count (AW+1 bits).
- Reset (reset=1 at a clock edge):
  - head = tail = count = 0.
  - Entry contents are don't-care.
  - Outputs after reset: empty=1, st_ready=1, dm_we=0, ld_hit_be=0, ld_full_hit=0, count=0.
  - Reset overrides any push or pop in the same cycle. Reset during a non-empty drain discards all entries; no further dm_we.
- Push: push = st_valid && st_ready.
  - Writes the entry at tail; tail <= tail+1.
  - st_valid while full is ignored; no entry is overwritten. The upstream must hold the request.
  - A push with st_be == 0 is still enqueued and drained; the memory writes nothing meaningful.
- Pop: dm_we = !empty, combinational from the head entry. pop = dm_we && dm_ready; head <= head+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
  - neither: unchanged.
- Full with simultaneous pop: st_ready stays 0. A push is not accepted in the same cycle a full buffer pops.
- Empty with simultaneous push: no pop, since dm_we=0. The entry appears on dm_* in the next cycle.
- Latency: a store accepted at edge N is presented on dm_* at the earliest in the cycle after edge N. Minimum push-to-memory latency is 1 cycle.
- Ordering: strict FIFO. Stores drain in acceptance order.
- Load probe (purely combinational):
  - Considers only entries currently occupied. The same-cycle incoming store is excluded; the head is included even if popping this cycle.
  - Per byte lane i, the youngest occupied entry with waddr == ld_addr[31:2] and be[i]=1 supplies the byte. ld_hit_be[i]=1 in that case.
  - Lanes with no supplier: ld_hit_be[i]=0 and the data byte is 0.
  - The MEM stage merges ld_hit_data with memory data per lane, then performs sign/zero extension.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined:
  - A push whose st_addr[31:2] equals the tail-1 entry's waddr merges into that entry instead of allocating a new one. This applies only when count>0 and that entry is not the head being popped this cycle.
  - Merge rule: be |= st_be; for each lane with st_be set, data byte is replaced; pc is replaced with st_pc.
  - A merge does not change count or tail.
  - st_ready = !full || (coalesce condition true).
- Undefined: every accepted store allocates a new entry; behaviour exactly as above.

Test Plan:
- Reset then single store (addr 0x0000_0010, be 4'b1111, data 0xDEADBEEF, dm_ready=1) -> dm_we=1 the next cycle with dm_addr 0x10 and dm_wdata 0xDEADBEEF; empty=1 the cycle after.
- dm_ready=0, push 5 stores at DEPTH=4 -> count reaches 4, st_ready=0, 5th ignored. Raise dm_ready -> 4 writes in order with pops on consecutive cycles, head wraps to 0.
- Full buffer, st_valid=1 and dm_ready=1 in the same cycle -> one pop, no push, count 3; push accepted the next cycle.
- Buffer holds sb 0x21 (be 0010, data 0x0000AA00) then sh 0x22 (be 1100, data 0xBBCC0000). Probe ld_addr 0x20 -> ld_hit_be 4'b1110, ld_hit_data 0xBBCCAA00, ld_full_hit=0.
- Two stores to the same word, be 4'b1111 data 0x11111111 then be 4'b0001 data 0x00000022. Probe that word -> ld_hit_data 0x11111122, ld_full_hit=1. With STORE_BUFFER_COALESCE_EN defined: count=1 and a single drain of 0x11111122.
- Reset asserted while count=3 and dm_ready=1 -> next cycle count=0, dm_we=0, no write of the remaining entries.

Source files
------------

// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and data memory, with a per-lane load-forwarding probe.
// Optional: define STORE_BUFFER_COALESCE_EN to merge same-word stores into the youngest entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [3:0]    st_be,
    input  logic [31:0]   st_data,
    input  logic [31:0]   st_pc,
    output logic          dm_we,
    input  logic          dm_ready,
    output logic [31:0]   dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_wdata,
    output logic [31:0]   dm_pc,
    input  logic [31:0]   ld_addr,
    output logic [3:0]    ld_hit_be,
    output logic [31:0]   ld_hit_data,
    output logic          ld_full_hit,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [29:0]   mem_waddr [DEPTH];
    logic [3:0]    mem_be    [DEPTH];
    logic [31:0]   mem_data  [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] last;
    logic [AW-1:0] idx;
    logic          full;
    logic          pop;
    logic          coal_hit;
    logic          merge;
    logic          alloc;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign last  = tail - AW'(1);

    assign dm_we    = !empty;
    assign dm_addr  = {mem_waddr[head], 2'b00};
    assign dm_be    = mem_be[head];
    assign dm_wdata = mem_data[head];
    assign dm_pc    = mem_pc[head];
    assign pop      = dm_we && dm_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    // The youngest entry is only mergeable if it is not leaving this cycle.
    assign coal_hit = !empty && (mem_waddr[last] == st_addr[31:2]) &&
                      !(pop && (last == head));
`else
    assign coal_hit = 1'b0;
`endif

    assign st_ready = !full || coal_hit;
    assign merge    = st_valid && coal_hit;
    assign alloc    = st_valid && !full && !coal_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) tail <= tail + AW'(1);
            if (pop)   head <= head + AW'(1);
            case ({alloc, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents carry no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_waddr[tail] <= st_addr[31:2];
            mem_be[tail]    <= st_be;
            mem_data[tail]  <= st_data;
            mem_pc[tail]    <= st_pc;
        end else if (merge) begin
            mem_be[last] <= mem_be[last] | st_be;
            mem_pc[last] <= st_pc;
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem_data[last][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    // Walk oldest to youngest so younger matching lanes overwrite older ones.
    always_comb begin
        ld_hit_be   = '0;
        ld_hit_data = '0;
        idx         = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (((AW+1)'(k) < count) && (mem_waddr[idx] == ld_addr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_be[idx][i]) begin
                        ld_hit_be[i]            = 1'b1;
                        ld_hit_data[8*i +: 8]   = mem_data[idx][8*i +: 8];
                    end
                end
            end
        end
    end

    assign ld_full_hit = (ld_hit_be == 4'b1111);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          dm_we;
    logic          dm_ready;
    logic [31:0]   dm_addr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_pc;
    logic [31:0]   ld_addr;
    logic [3:0]    ld_hit_be;
    logic [31:0]   ld_hit_data;
    logic          ld_full_hit;
    logic          empty;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_be(st_be), .st_data(st_data), .st_pc(st_pc),
        .dm_we(dm_we), .dm_ready(dm_ready), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .ld_addr(ld_addr), .ld_hit_be(ld_hit_be), .ld_hit_data(ld_hit_data),
        .ld_full_hit(ld_full_hit), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks all outputs against the model before
    // the edge, then advances the model across the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] p, input logic r,
                        input logic [31:0] la, input logic rs);
        ent_t        e;
        logic        coal;
        logic        exp_ready;
        logic        do_pop;
        logic [3:0]  hbe;
        logic [31:0] hdata;
        st_valid = v; st_addr = a; st_be = b; st_data = d; st_pc = p;
        dm_ready = r; ld_addr = la; reset = rs;
        @(negedge clk);
        coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
        coal = (q.size() > 0) && (q[q.size()-1].waddr == a[31:2]) && !(r && q.size() == 1);
`endif
        exp_ready = (q.size() < DEPTH) || coal;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("st_ready", 32'(st_ready), 32'(exp_ready));
        chk("dm_we", 32'(dm_we), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("dm_addr", dm_addr, {q[0].waddr, 2'b00});
            chk("dm_be", 32'(dm_be), 32'(q[0].be));
            chk("dm_wdata", dm_wdata, q[0].data);
            chk("dm_pc", dm_pc, q[0].pc);
        end
        hbe = '0;
        hdata = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].waddr == la[31:2] && q[k].be[i]) begin
                    hbe[i] = 1'b1;
                    hdata[8*i +: 8] = q[k].data[8*i +: 8];
                    break;
                end
            end
        end
        chk("ld_hit_be", 32'(ld_hit_be), 32'(hbe));
        chk("ld_hit_data", ld_hit_data, hdata);
        chk("ld_full_hit", 32'(ld_full_hit), 32'(hbe == 4'b1111));
        if (rs) begin
            q.delete();
        end else begin
            do_pop = (q.size() > 0) && r;
            if (do_pop) void'(q.pop_front());
            if (v && exp_ready) begin
                if (coal) begin
                    e = q[q.size()-1];
                    e.be = e.be | b;
                    e.pc = p;
                    for (int i = 0; i < 4; i++) if (b[i]) e.data[8*i +: 8] = d[8*i +: 8];
                    q[q.size()-1] = e;
                end else begin
                    e.waddr = a[31:2]; e.be = b; e.data = d; e.pc = p;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        step(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, r, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        st_valid = 0; st_addr = 0; st_be = 0; st_data = 0; st_pc = 0;
        dm_ready = 0; ld_addr = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_hit_be", 32'(ld_hit_be), 32'd0);
        chk("rst_full_hit", 32'(ld_full_hit), 32'd0);

        // single store, one-cycle latency to memory
        step(1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h1000, 1, 32'h0, 0);
        chk("t1_we", 32'(dm_we), 32'd1);
        chk("t1_addr", dm_addr, 32'h10);
        chk("t1_data", dm_wdata, 32'hDEADBEEF);
        idle(1);
        chk("t1_empty", 32'(empty), 32'd1);

        // fill past capacity, then drain in order
        for (int i = 0; i < 5; i++)
            step(1, 32'h40 + 32'(i*4), 4'hF, 32'hA0 + 32'(i), 32'h2000 + 32'(i), 0, 32'h0, 0);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_ready", 32'(st_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", dm_wdata, 32'hA0 + 32'(i));
            idle(1);
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // full buffer with simultaneous push attempt and pop
        for (int i = 0; i < 4; i++)
            step(1, 32'h80 + 32'(i*4), 4'hF, 32'hB0 + 32'(i), 32'h3000, 0, 32'h0, 0);
        step(1, 32'h90, 4'hF, 32'hC0, 32'h3100, 1, 32'h0, 0);
        chk("t3_count_pop", 32'(count), 32'd3);
        step(1, 32'h90, 4'hF, 32'hC0, 32'h3100, 0, 32'h0, 0);
        chk("t3_count_push", 32'(count), 32'd4);
        repeat (4) idle(1);

        // partial-lane forwarding from two stores into one word
        step(1, 32'h21, 4'b0010, 32'h0000AA00, 32'h4000, 0, 32'h0, 0);
        step(1, 32'h22, 4'b1100, 32'hBBCC0000, 32'h4004, 0, 32'h0, 0);
        st_valid = 0; ld_addr = 32'h20;
        #1;
        chk("t4_hit_be", 32'(ld_hit_be), 32'hE);
        chk("t4_hit_data", ld_hit_data, 32'hBBCCAA00);
        chk("t4_full_hit", 32'(ld_full_hit), 32'd0);
        repeat (2) idle(1);

        // younger store overrides one lane of an older full-word store
        step(1, 32'h30, 4'hF, 32'h11111111, 32'h5000, 0, 32'h0, 0);
        step(1, 32'h30, 4'h1, 32'h00000022, 32'h5004, 0, 32'h0, 0);
        st_valid = 0; ld_addr = 32'h30;
        #1;
        chk("t5_hit_data", ld_hit_data, 32'h11111122);
        chk("t5_full_hit", 32'(ld_full_hit), 32'd1);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_drain", dm_wdata, 32'h11111122);
`else
        chk("t5_count", 32'(count), 32'd2);
`endif
        repeat (2) idle(1);

        // reset while draining discards remaining entries
        for (int i = 0; i < 3; i++)
            step(1, 32'h60 + 32'(i*4), 4'hF, 32'hD0 + 32'(i), 32'h6000, 0, 32'h0, 0);
        step(0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 32'h0, 1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_dm_we", 32'(dm_we), 32'd0);
        idle(1);

        // randomized traffic over a small address window to provoke hits and merges
        for (int n = 0; n < 600; n++) begin
            ra = {26'h0, 4'($urandom_range(0, 3)), 2'($urandom)} + 32'h100;
            step(1'($urandom_range(0, 2) != 0), ra, 4'($urandom), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0),
                 {26'h0, 4'($urandom_range(0, 3)), 2'($urandom)} + 32'h100,
                 1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
